// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Handshake bundle between the PC/fetch stage, the fetch queue and decode.
//
// Signals
//   fetch_valid     upstream PC/instruction pair valid
//   fetch_pc        instruction address from the PC stage
//   fetch_instr     instruction word read at fetch_pc
//   fetch_ready     queue can accept a pair this cycle
//   deq_valid       head entry valid for decode
//   deq_ready       decode consumes the head this cycle
//   deq_pc          PC of head entry
//   deq_instr       instruction of head entry
//   deq_misaligned  head entry PC not word-aligned
//
// Modports
//   master  the environment side (fetch stage producer + decode consumer)
//   slave   the queue itself
// -----------------------------------------------------------------------------
interface fetch_queue_if;

   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        fetch_ready;

   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_pc;
   logic [31:0] deq_instr;
   logic        deq_misaligned;

   modport master (
      output fetch_valid,
      output fetch_pc,
      output fetch_instr,
      input  fetch_ready,
      input  deq_valid,
      output deq_ready,
      input  deq_pc,
      input  deq_instr,
      input  deq_misaligned
   );

   modport slave (
      input  fetch_valid,
      input  fetch_pc,
      input  fetch_instr,
      output fetch_ready,
      output deq_valid,
      input  deq_ready,
      output deq_pc,
      output deq_instr,
      output deq_misaligned
   );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO decoupling the PC/fetch stage from decode. Holds up to DEPTH
// PC/instruction pairs, strict FIFO order, one-cycle latency (no bypass).
// A flush (front-end redirect) empties the queue at the next edge.
//
// Parameters
//   DEPTH  number of entries, power of two in 2..16
//   CNT_W  width of count, must equal log2(DEPTH)+1
//
// Ports
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high reset (pointers and count only)
//   flush  discard all queued entries; enqueue/dequeue ignored this cycle
//   bus    fetch_queue_if.slave: fetch_* producer side, deq_* consumer side
//   count  number of valid entries, 0..DEPTH
//
// Build option
//   FETCH_MISALIGN_CHECK_EN  when defined, each entry also stores whether its
//                            PC was not word-aligned and the head's flag is
//                            driven on deq_misaligned; otherwise that output
//                            is tied low and no flag storage exists.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   fetch_queue_if.slave     bus,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   // Elaboration-time parameter sanity checks
   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two between 2 and 16");
   end
   if (CNT_W != PTR_W + 1) begin : g_bad_cnt_w
      $error("fetch_queue: CNT_W must equal log2(DEPTH)+1");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Entry storage is deliberately not reset; validity is carried by count.
   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic full;
   logic empty;
   logic enq;
   logic deq;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Full refuses a pair even when the head leaves in the same cycle: ready
   // depends on state only, keeping it free of any path from deq_ready.
   assign enq = bus.fetch_valid && !full && !flush;
   assign deq = !empty && bus.deq_ready && !flush;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives a gap-free wrap.
         if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state registers (reset has priority over everything)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------------
   // A write during reset is harmless: the pointers return to zero and the
   // entry is invisible until rewritten.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[wr_ptr_q]    <= bus.fetch_pc;
         instr_mem[wr_ptr_q] <= bus.fetch_instr;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.fetch_ready = !full;
   assign bus.deq_valid   = !empty;
   assign count           = count_q;

   // Head fields are forced to zero when nothing is queued so decode never
   // sees stale storage contents.
   always_comb begin
      bus.deq_pc    = '0;
      bus.deq_instr = '0;
      if (!empty) begin
         bus.deq_pc    = pc_mem[rd_ptr_q];
         bus.deq_instr = instr_mem[rd_ptr_q];
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic mis_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (enq) begin
         mis_mem[wr_ptr_q] <= (bus.fetch_pc[1:0] != 2'b00);
      end
   end

   always_comb begin
      bus.deq_misaligned = 1'b0;
      if (!empty) begin
         bus.deq_misaligned = mis_mem[rd_ptr_q];
      end
   end
`else
   assign bus.deq_misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter CNT_W, default 3, width of the occupancy count; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all queued entries (redirect from pc_src path).
REQ-006 fetch_valid  input  1  upstream PC/instruction pair valid.
REQ-007 fetch_pc  input  32  instruction address from the PC stage.
REQ-008 fetch_instr  input  32  instruction word read at fetch_pc.
REQ-009 fetch_ready  output  1  queue can accept a pair this cycle.
REQ-010 deq_valid  output  1  head entry valid for decode.
REQ-011 deq_ready  input  1  decode consumes head this cycle.
REQ-012 deq_pc  output  32  PC of head entry.
REQ-013 deq_instr  output  32  instruction of head entry.
REQ-014 deq_misaligned  output  1  head entry PC not word-aligned (see Configuration).
REQ-015 count  output  CNT_W  number of valid entries, 0 to DEPTH.

Function
REQ-016 Enqueue SHALL occur when fetch_valid && fetch_ready && !flush; the pair is written at the write pointer.
REQ-017 Dequeue SHALL occur when deq_valid && deq_ready && !flush; the read pointer advances.
REQ-018 fetch_ready SHALL be combinational !full (count != DEPTH); a full queue SHALL NOT accept a pair, even if a dequeue occurs in the same cycle.
REQ-019 deq_valid SHALL be combinational (count != 0).
REQ-020 No bypass: a pair enqueued at edge N SHALL first appear on deq_* in the cycle after edge N (1-cycle latency).
REQ-021 Simultaneous enqueue and dequeue on a non-full, non-empty queue SHALL leave count unchanged and advance both pointers.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-023 count SHALL increment on enqueue-only, decrement on dequeue-only, and be unchanged otherwise.
REQ-024 Order SHALL be strict FIFO; no entry dropped or duplicated except by flush or reset.
REQ-025 flush SHALL, at the next edge, set count=0 and pointers=0; enqueue and dequeue in the flush cycle are ignored.
REQ-026 When deq_valid=0, deq_pc, deq_instr and deq_misaligned SHALL be 0.
REQ-027 Entry storage SHALL not be reset; only pointers and count SHALL be.

Reset
REQ-028 On reset at a posedge: count=0, pointers=0, deq_valid=0, fetch_ready=1, deq_pc=0, deq_instr=0, deq_misaligned=0.
REQ-029 reset SHALL take priority over flush, enqueue and dequeue; reset mid-operation discards all entries.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN: when defined, each entry SHALL store fetch_pc[1:0]!=0 and drive it on deq_misaligned for the head entry.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, deq_misaligned SHALL be tied 0 and no extra storage instantiated.

Verification
REQ-032 Reset, then enqueue pc 0x0/instr 0x00000013 -> next cycle deq_valid=1, deq_pc=0x0, count=1.
REQ-033 deq_ready=0, enqueue pcs 0x0,0x4,0x8,0xC -> count=4, fetch_ready=0; fifth pair 0x10 with fetch_valid=1 is not accepted.
REQ-034 Full queue, deq_ready=1 and fetch_valid=1 for one cycle -> head 0x0 removed, 0x10 not accepted, count=3.
REQ-035 Continuous enq/deq for 10 pairs 0x0..0x24 -> output order 0x0..0x24, pointer wrap clean, count steady.
REQ-036 Queue holding 3 entries, flush=1 with fetch_valid=1 pc 0x100 -> next cycle count=0, deq_valid=0; 0x100 not queued.
REQ-037 With FETCH_MISALIGN_CHECK_EN, enqueue pc 0x6 -> deq_misaligned=1 at head; without macro -> 0.
